alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decodes RV32I ALU-class instructions (R-type, I-type, LUI, AUIPC) into an
// ALU operation select plus two operands, and issues them to the EX stage
// through a two-deep elastic buffer: a visible output register backed by a
// one-entry skid register. Decoding happens at acceptance, so the register-file
// operands are captured once and never re-sampled while the entry waits.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   instr_valid_i  upstream instruction valid
//   instr_ready_o  stage can accept (registered)
//   instr_i        RV32I instruction word
//   pc_i           instruction PC
//   rs1_data_i     register-file rs1 value
//   rs2_data_i     register-file rs2 value
//   flush_i        discard all held entries (and any same-cycle acceptance)
//   ex_valid_o     issued entry valid
//   ex_ready_i     EX stage consumes the entry
//   alu_sel_o      ALU operation select
//   op_a_o         ALU operand A
//   op_b_o         ALU operand B
//   rd_o           destination register
//   rd_we_o        writeback enable
//   illegal_o      unsupported encoding
// -----------------------------------------------------------------------------
module alu_issue_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [3:0]  alu_sel_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        illegal_o
);

  // ALU operation select codes
  localparam logic [3:0] SEL_AND   = 4'b0000;
  localparam logic [3:0] SEL_OR    = 4'b0001;
  localparam logic [3:0] SEL_ADD   = 4'b0010;
  localparam logic [3:0] SEL_SUB   = 4'b0011;
  localparam logic [3:0] SEL_SLT   = 4'b0100;
  localparam logic [3:0] SEL_LUI   = 4'b0110;
  localparam logic [3:0] SEL_XOR   = 4'b0111;
  localparam logic [3:0] SEL_SLL   = 4'b1000;
  localparam logic [3:0] SEL_SRL   = 4'b1001;
  localparam logic [3:0] SEL_AUIPC = 4'b1010;
  localparam logic [3:0] SEL_SLTU  = 4'b1011;
  localparam logic [3:0] SEL_SRA   = 4'b1100;

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 patterns: the base encoding and the SUB/SRA alternate encoding
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded, issue-ready entry
  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } entry_t;

  // Instruction fields
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rd_idx_s;
  logic        f7_base_s;
  logic        f7_alt_s;
  logic [31:0] imm_i_s;
  logic [31:0] shamt_s;
  logic [31:0] imm_u_s;
  logic        unused_s;

  // Decode results
  logic        legal_s;
  logic [3:0]  sel_s;
  logic [31:0] op_a_s;
  logic [31:0] op_b_s;
  entry_t      dec_s;

  // Storage
  entry_t      out_r;
  logic        out_valid_r;
  entry_t      skid_r;
  logic        skid_valid_r;
  logic        ready_r;

  // Handshake qualifiers
  logic        accept_s;
  logic        out_free_s;

  assign opcode_s  = instr_i[6:0];
  assign rd_idx_s  = instr_i[11:7];
  assign funct3_s  = instr_i[14:12];
  assign funct7_s  = instr_i[31:25];
  assign f7_base_s = (funct7_s == F7_BASE);
  assign f7_alt_s  = (funct7_s == F7_ALT);

  // I-type immediate is sign-extended; SLTIU also uses it, only the compare is unsigned.
  assign imm_i_s = {{20{instr_i[31]}}, instr_i[31:20]};
  // Shift-immediates carry only a 5-bit shift amount.
  assign shamt_s = {27'd0, instr_i[24:20]};
  // LUI/AUIPC hand the raw 20-bit field to the ALU; the ALU does the positioning.
  assign imm_u_s = {12'd0, instr_i[31:12]};

  // The rs1 index is resolved by the register file upstream; only its data is used here.
  assign unused_s = ^instr_i[19:15];

  // Operation and operand selection per instruction class
  always_comb begin
    legal_s = 1'b0;
    sel_s   = SEL_AND;
    op_a_s  = 32'd0;
    op_b_s  = 32'd0;
    case (opcode_s)
      OPC_OP: begin
        op_a_s = rs1_data_i;
        op_b_s = rs2_data_i;
        case (funct3_s)
          3'b000: begin
            sel_s   = f7_alt_s ? SEL_SUB : SEL_ADD;
            legal_s = f7_base_s | f7_alt_s;
          end
          3'b001: begin
            sel_s   = SEL_SLL;
            legal_s = f7_base_s;
          end
          3'b010: begin
            sel_s   = SEL_SLT;
            legal_s = f7_base_s;
          end
          3'b011: begin
            sel_s   = SEL_SLTU;
            legal_s = f7_base_s;
          end
          3'b100: begin
            sel_s   = SEL_XOR;
            legal_s = f7_base_s;
          end
          3'b101: begin
            sel_s   = f7_alt_s ? SEL_SRA : SEL_SRL;
            legal_s = f7_base_s | f7_alt_s;
          end
          3'b110: begin
            sel_s   = SEL_OR;
            legal_s = f7_base_s;
          end
          3'b111: begin
            sel_s   = SEL_AND;
            legal_s = f7_base_s;
          end
          default: begin
            legal_s = 1'b0;
          end
        endcase
      end
      OPC_OP_IMM: begin
        op_a_s = rs1_data_i;
        op_b_s = imm_i_s;
        case (funct3_s)
          3'b000: begin
            sel_s   = SEL_ADD;
            legal_s = 1'b1;
          end
          3'b001: begin
            sel_s   = SEL_SLL;
            op_b_s  = shamt_s;
            legal_s = f7_base_s;
          end
          3'b010: begin
            sel_s   = SEL_SLT;
            legal_s = 1'b1;
          end
          3'b011: begin
            sel_s   = SEL_SLTU;
            legal_s = 1'b1;
          end
          3'b100: begin
            sel_s   = SEL_XOR;
            legal_s = 1'b1;
          end
          3'b101: begin
            sel_s   = f7_alt_s ? SEL_SRA : SEL_SRL;
            op_b_s  = shamt_s;
            legal_s = f7_base_s | f7_alt_s;
          end
          3'b110: begin
            sel_s   = SEL_OR;
            legal_s = 1'b1;
          end
          3'b111: begin
            sel_s   = SEL_AND;
            legal_s = 1'b1;
          end
          default: begin
            legal_s = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        sel_s   = SEL_LUI;
        op_a_s  = 32'd0;
        op_b_s  = imm_u_s;
        legal_s = 1'b1;
      end
      OPC_AUIPC: begin
        sel_s   = SEL_AUIPC;
        op_a_s  = pc_i;
        op_b_s  = imm_u_s;
        legal_s = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Assemble the entry; illegal encodings are neutralised so EX sees a harmless no-op.
  always_comb begin
    dec_s = '0;
    if (legal_s) begin
      dec_s.sel     = sel_s;
      dec_s.op_a    = op_a_s;
      dec_s.op_b    = op_b_s;
      dec_s.rd      = rd_idx_s;
      dec_s.rd_we   = (rd_idx_s != 5'd0);
      dec_s.illegal = 1'b0;
    end else begin
      dec_s.illegal = 1'b1;
    end
  end

  assign accept_s   = instr_valid_i & ready_r;
  // The output register may be overwritten when it is empty or being consumed now.
  assign out_free_s = ~out_valid_r | ex_ready_i;

  // Output/skid buffer: reset beats flush, flush beats consume and accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_r        <= '0;
      out_valid_r  <= 1'b0;
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
    end else if (flush_i) begin
      out_r        <= '0;
      out_valid_r  <= 1'b0;
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        // Skid is older than anything upstream; ready was low, so nothing new arrives.
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
        ready_r      <= 1'b1;
      end else if (accept_s) begin
        out_r       <= dec_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      // Output is stalled: park the new entry and stop accepting until it drains.
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
      ready_r      <= 1'b0;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

  assign instr_ready_o = ready_r;
  assign ex_valid_o    = out_valid_r;
  assign alu_sel_o     = out_r.sel;
  assign op_a_o        = out_r.op_a;
  assign op_b_o        = out_r.op_b;
  assign rd_o          = out_r.rd;
  assign rd_we_o       = out_r.rd_we;
  assign illegal_o     = out_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [3:0]  alu_sel_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic        illegal_o;

  alu_issue_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .instr_i(instr_i), .pc_i(pc_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .alu_sel_o(alu_sel_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  // Reference model: the stage behaves as an in-order queue of at most two
  // decoded instructions; the head is what EX sees.
  exp_t q[$];
  bit   exp_ready;
  bit   zero_expected;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Select code by funct3 for the base (funct7 = 0) arithmetic group
  int   sel_by_f3 [8] = '{2, 8, 4, 11, 7, 9, 1, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int sel = -1;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    if (opc == 7'h33) begin
      a = r1; b = r2;
      if (f7 == 7'h00) sel = sel_by_f3[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) sel = 3;
      else if (f7 == 7'h20 && f3 == 3'd5) sel = 12;
    end else if (opc == 7'h13) begin
      a = r1;
      b = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 3'd1 || f3 == 3'd5) begin
        b = 32'(ins[24:20]);
        if (f7 == 7'h00) sel = sel_by_f3[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) sel = 12;
      end else begin
        sel = sel_by_f3[f3];
      end
    end else if (opc == 7'h37) begin
      a = 32'd0; b = ins >> 12; sel = 6;
    end else if (opc == 7'h17) begin
      a = pc; b = ins >> 12; sel = 10;
    end
    if (sel < 0) begin
      e = '0;
      e.ill = 1'b1;
    end else begin
      e.sel = 4'(sel);
      e.a   = a;
      e.b   = b;
      e.rd  = ins[11:7];
      e.we  = (ins[11:7] != 5'd0);
      e.ill = 1'b0;
    end
    return e;
  endfunction

  task automatic model_update();
    bit acc;
    if (rst_i || flush_i) begin
      q.delete();
      exp_ready     = 1'b1;
      zero_expected = 1'b1;
    end else begin
      acc = instr_valid_i && exp_ready;
      if (q.size() > 0 && ex_ready_i) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_decode(instr_i, pc_i, rs1_data_i, rs2_data_i));
        zero_expected = 1'b0;
      end
      exp_ready = (q.size() < 2);
    end
  endtask

  task automatic check_outputs();
    exp_t h;
    chk("ready", 32'(instr_ready_o), 32'(exp_ready));
    chk("valid", 32'(ex_valid_o), 32'(q.size() > 0));
    if (q.size() > 0) begin
      h = q[0];
      chk("sel", 32'(alu_sel_o), 32'(h.sel));
      chk("op_a", op_a_o, h.a);
      chk("op_b", op_b_o, h.b);
      chk("rd_we", 32'(rd_we_o), 32'(h.we));
      chk("illegal", 32'(illegal_o), 32'(h.ill));
      if (!h.ill) chk("rd", 32'(rd_o), 32'(h.rd));
    end else if (zero_expected) begin
      chk("zero_data", {alu_sel_o, 5'd0, rd_o, rd_we_o, illegal_o, 16'd0}, 32'd0);
      chk("zero_ops", op_a_o | op_b_o, 32'd0);
    end
  endtask

  // One clock: inputs already driven, model advances at the edge, outputs checked after it.
  task automatic step();
    @(posedge clk_i);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    rs1_data_i    = r1;
    rs2_data_i    = r2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    logic [6:0]  f7 = 7'h00;
    int k = $urandom_range(0, 9);
    if (k <= 3 || k == 4 || k == 5) begin
      if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
      if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
      if (k <= 3) w = {f7, w[24:15], f3, w[11:7], 7'h33};
      else if (f3 == 3'd1 || f3 == 3'd5) w = {f7, w[24:15], f3, w[11:7], 7'h13};
      else w = {w[31:15], f3, w[11:7], 7'h13};
    end else if (k == 6) begin
      w = {w[31:15], f3, w[11:7], 7'h13};
    end else if (k == 7) begin
      w = {w[31:7], 7'h37};
    end else if (k == 8) begin
      w = {w[31:7], 7'h17};
    end
    return w;
  endfunction

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; ex_ready_i = 1'b0;
    instr_i = 32'd0; pc_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    exp_ready = 1'b1; zero_expected = 1'b1;
    step();
    step();
    chk("reset_ready", 32'(instr_ready_o), 32'd1);
    rst_i = 1'b0;

    // ADDI x5, x0, -1
    ex_ready_i = 1'b1;
    offer(32'hFFF00293, 32'd0, 32'd0);
    step();
    chk("addi_valid", 32'(ex_valid_o), 32'd1);
    chk("addi_sel", 32'(alu_sel_o), 32'h2);
    chk("addi_b", op_b_o, 32'hFFFFFFFF);
    chk("addi_rd", 32'(rd_o), 32'd5);
    chk("addi_we", 32'(rd_we_o), 32'd1);

    // SUB x3, x1, x2 and its bad-funct7 variant
    offer(32'h402081B3, 32'h10, 32'h3);
    step();
    chk("sub_sel", 32'(alu_sel_o), 32'h3);
    chk("sub_a", op_a_o, 32'h10);
    chk("sub_b", op_b_o, 32'h3);
    chk("sub_rd", 32'(rd_o), 32'd3);
    offer(32'hFE2081B3, 32'h10, 32'h3);
    step();
    chk("sub7f_ill", 32'(illegal_o), 32'd1);
    chk("sub7f_we", 32'(rd_we_o), 32'd0);

    // LUI, AUIPC, SRAI
    offer(32'h123450B7, 32'h55, 32'h66);
    step();
    chk("lui_sel", 32'(alu_sel_o), 32'h6);
    chk("lui_a", op_a_o, 32'h0);
    chk("lui_b", op_b_o, 32'h00012345);
    pc_i = 32'h100;
    offer(32'h00001097, 32'h55, 32'h66);
    step();
    chk("auipc_sel", 32'(alu_sel_o), 32'hA);
    chk("auipc_a", op_a_o, 32'h100);
    chk("auipc_b", op_b_o, 32'h1);
    offer(32'h4030D113, 32'h80000000, 32'h0);
    step();
    chk("srai_sel", 32'(alu_sel_o), 32'hC);
    chk("srai_b", op_b_o, 32'h3);

    // Illegal opcode between legal neighbours
    offer(32'h00700313, 32'd1, 32'd0);
    step();
    offer(32'h0000000B, 32'd2, 32'd3);
    step();
    chk("illop_ill", 32'(illegal_o), 32'd1);
    chk("illop_sel", 32'(alu_sel_o), 32'd0);
    chk("illop_we", 32'(rd_we_o), 32'd0);
    offer(32'h002083B3, 32'd4, 32'd5);
    step();
    chk("after_ill_rd", 32'(rd_o), 32'd7);
    instr_valid_i = 1'b0;
    step();

    // Backpressure: I1 in output, I2 in skid, I3 stalls
    ex_ready_i = 1'b0;
    offer(32'h00100093, 32'd10, 32'd0);
    step();
    offer(32'h00200113, 32'd20, 32'd0);
    step();
    chk("bp_ready_low", 32'(instr_ready_o), 32'd0);
    offer(32'h00300193, 32'd30, 32'd0);
    step();
    chk("bp_hold_rd", 32'(rd_o), 32'd1);
    chk("bp_hold_a", op_a_o, 32'd10);
    ex_ready_i = 1'b1;
    step();
    chk("bp_second", 32'(rd_o), 32'd2);
    chk("bp_ready_back", 32'(instr_ready_o), 32'd1);
    step();
    chk("bp_third", 32'(rd_o), 32'd3);
    instr_valid_i = 1'b0;
    step();
    chk("bp_drained", 32'(ex_valid_o), 32'd0);

    // Flush with both entries full and a same-cycle offer
    ex_ready_i = 1'b0;
    offer(32'h00100093, 32'd1, 32'd0); step();
    offer(32'h00200113, 32'd2, 32'd0); step();
    flush_i = 1'b1;
    offer(32'h00300193, 32'd3, 32'd0);
    step();
    flush_i = 1'b0;
    chk("flush_valid", 32'(ex_valid_o), 32'd0);
    chk("flush_ready", 32'(instr_ready_o), 32'd1);
    instr_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    step();
    chk("flush_no_issue", 32'(ex_valid_o), 32'd0);

    // Same again with reset, which also clears the data outputs
    ex_ready_i = 1'b0;
    offer(32'h00100093, 32'd1, 32'd0); step();
    offer(32'h00200113, 32'd2, 32'd0); step();
    rst_i = 1'b1; flush_i = 1'b1;
    offer(32'h00300193, 32'd3, 32'd0);
    step();
    rst_i = 1'b0; flush_i = 1'b0;
    chk("rst_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_a", op_a_o, 32'd0);
    chk("rst_b", op_b_o, 32'd0);
    chk("rst_misc", {23'd0, alu_sel_o, rd_o}, 32'd0);
    instr_valid_i = 1'b0;
    step();

    // Randomised traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      instr_valid_i = ($urandom_range(0, 3) != 0);
      instr_i       = rand_instr();
      pc_i          = $urandom;
      rs1_data_i    = $urandom;
      rs2_data_i    = $urandom;
      ex_ready_i    = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 39) == 0);
      rst_i         = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
